// File: rtl/qam_demap_pack.sv
`default_nettype none
// ============================================================================
// Module   : qam_demap_pack
// Purpose  : Hard-decision Gray QAM demapper (BPSK/QPSK/16-QAM/64-QAM) with
//            LSB-first packing of the demapped bit stream into 32-bit words.
//            At end of frame a zero-padded partial word is flushed and its
//            valid-bit count is reported on BITS_O.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_I         clock, rising edge
//   RST_I         asynchronous active-low reset
//   DAT_I[31:0]   symbol: [31:16] Im, [15:0] Re, signed Q3.13
//   WE_I/STB_I/CYC_I  upstream strobe, CYC_I spans the frame
//   ACK_O         symbol accepted this cycle
//   MOD_I[1:0]    00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM (latched at frame start)
//   DAT_O[31:0]   packed bits, first bit in DAT_O[0]
//   BITS_O[5:0]   valid bits in DAT_O
//   CYC_O/STB_O/WE_O  downstream frame / word valid / write enable
//   ACK_I         downstream accepts word when STB_O & ACK_I
// Configuration
//   QAM64_EN      when defined, builds the 64-QAM slicer. Otherwise MOD_I=11
//                 is sliced as 16-QAM (4 bits per symbol).
// ============================================================================
module qam_demap_pack (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  input  logic [1:0]  MOD_I,
  output logic [31:0] DAT_O,
  output logic [5:0]  BITS_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  // Decision thresholds on |x| in Q3.13
  localparam logic [15:0] TH16_B1 = 16'd5181;  // 2/sqrt(10)
`ifdef QAM64_EN
  localparam logic [15:0] TH64_B1 = 16'd5056;  // 4/sqrt(42)
  localparam logic [15:0] TH64_LO = 16'd2528;  // 2/sqrt(42)
  localparam logic [15:0] TH64_HI = 16'd7584;  // 6/sqrt(42)
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  mode, mode_nx;
  logic [37:0] acc, acc_nx;
  logic [5:0]  fill, fill_nx;
  logic [31:0] dat_nx;
  logic [5:0]  bits_nx;
  logic        stb_nx, cyc_nx;

  logic        din_val, out_halt;

  // Magnitude with -32768 saturated to 32767 so it stays representable
  function automatic logic [15:0] mag(input logic [15:0] x);
    logic [15:0] neg;
    neg = ~x + 16'd1;
    if (!x[15])
      mag = x;
    else if (x == 16'h8000)
      mag = 16'h7FFF;
    else
      mag = neg;
  endfunction

  // ---------------------------------------------------------------- slicer
  logic [15:0] re_x, im_x, re_a, im_a;
  logic        re_b0, im_b0, re_b1q16, im_b1q16;
  logic [5:0]  sym_bits;
  logic [5:0]  sym_n;

  assign re_x     = DAT_I[15:0];
  assign im_x     = DAT_I[31:16];
  assign re_a     = mag(re_x);
  assign im_a     = mag(im_x);
  assign re_b0    = ~re_x[15];
  assign im_b0    = ~im_x[15];
  assign re_b1q16 = (re_a < TH16_B1);
  assign im_b1q16 = (im_a < TH16_B1);

`ifdef QAM64_EN
  logic re_b1q64, im_b1q64, re_b2q64, im_b2q64;
  assign re_b1q64 = (re_a < TH64_B1);
  assign im_b1q64 = (im_a < TH64_B1);
  assign re_b2q64 = (re_a > TH64_LO) && (re_a < TH64_HI);
  assign im_b2q64 = (im_a > TH64_LO) && (im_a < TH64_HI);
`endif

  // I bits occupy the low positions, Q bits follow
  always_comb begin
    sym_bits = 6'd0;
    sym_n    = 6'd0;
    case (mode)
      2'b00: begin
        sym_bits = {5'd0, re_b0};
        sym_n    = 6'd1;
      end
      2'b01: begin
        sym_bits = {4'd0, im_b0, re_b0};
        sym_n    = 6'd2;
      end
`ifdef QAM64_EN
      2'b11: begin
        sym_bits = {im_b2q64, im_b1q64, im_b0, re_b2q64, re_b1q64, re_b0};
        sym_n    = 6'd6;
      end
`endif
      default: begin
        sym_bits = {2'd0, im_b1q16, im_b0, re_b1q16, re_b0};
        sym_n    = 6'd4;
      end
    endcase
  end

  // -------------------------------------------------------------- handshake
  assign din_val  = WE_I & STB_I & CYC_I;
  assign out_halt = STB_O & ~ACK_I;
  assign ACK_O    = din_val & ~out_halt & (state == S_RUN);
  assign WE_O     = CYC_O;

  // ------------------------------------------------------- next-state logic
  logic [37:0] placed;
  logic [5:0]  sum;
  logic [31:0] flush_mask;

  assign placed     = acc | ({32'd0, sym_bits} << fill);
  assign sum        = fill + sym_n;
  assign flush_mask = (32'd1 << fill[4:0]) - 32'd1;

  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    acc_nx   = acc;
    fill_nx  = fill;
    dat_nx   = DAT_O;
    bits_nx  = BITS_O;
    stb_nx   = STB_O;
    cyc_nx   = CYC_O;

    // Word taken downstream; may be re-asserted below by a new word
    if (STB_O && ACK_I)
      stb_nx = 1'b0;

    case (state)
      S_IDLE: begin
        // Level start also catches a frame that rose before we got back here
        if (CYC_I) begin
          state_nx = S_RUN;
          mode_nx  = MOD_I;
          acc_nx   = 38'd0;
          fill_nx  = 6'd0;
        end
      end
      S_RUN: begin
        if (ACK_O) begin
          if (sum >= 6'd32) begin
            dat_nx  = placed[31:0];
            bits_nx = 6'd32;
            stb_nx  = 1'b1;
            cyc_nx  = 1'b1;
            acc_nx  = {32'd0, placed[37:32]};
            fill_nx = sum - 6'd32;
          end else begin
            acc_nx  = placed;
            fill_nx = sum;
          end
        end
        if (!CYC_I)
          state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        if (!out_halt) begin
          if (fill != 6'd0) begin
            dat_nx  = acc[31:0] & flush_mask;
            bits_nx = fill;
            stb_nx  = 1'b1;
            cyc_nx  = 1'b1;
            acc_nx  = 38'd0;
            fill_nx = 6'd0;
          end
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (!STB_O) begin
          cyc_nx   = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state  <= S_IDLE;
      mode   <= 2'b00;
      acc    <= 38'd0;
      fill   <= 6'd0;
      DAT_O  <= 32'd0;
      BITS_O <= 6'd0;
      STB_O  <= 1'b0;
      CYC_O  <= 1'b0;
    end else begin
      state  <= state_nx;
      mode   <= mode_nx;
      acc    <= acc_nx;
      fill   <= fill_nx;
      DAT_O  <= dat_nx;
      BITS_O <= bits_nx;
      STB_O  <= stb_nx;
      CYC_O  <= cyc_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qam_demap_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_demap_pack
// Purpose  : Scoreboard bench for qam_demap_pack. Expected words are queued
//            when each frame is issued; a monitor pops and compares whenever
//            a word is transferred (STB_O & ACK_I).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_demap_pack;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] DAT_I = 32'd0;
  logic        WE_I  = 1'b0;
  logic        STB_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic        ACK_O;
  logic [1:0]  MOD_I = 2'b00;
  logic [31:0] DAT_O;
  logic [5:0]  BITS_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I = 1'b1;

  qam_demap_pack dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .DAT_I (DAT_I),
    .WE_I  (WE_I),
    .STB_I (STB_I),
    .CYC_I (CYC_I),
    .ACK_O (ACK_O),
    .MOD_I (MOD_I),
    .DAT_O (DAT_O),
    .BITS_O(BITS_O),
    .CYC_O (CYC_O),
    .STB_O (STB_O),
    .WE_O  (WE_O),
    .ACK_I (ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [31:0] dat;
    logic [5:0]  bits;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every transferred word against the scoreboard
  always @(negedge CLK_I) begin
    if (RST_I && STB_O && ACK_I) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h bits %0d expected none", DAT_O, BITS_O);
      end else begin
        mon_e = sb.pop_front();
        check("word_dat", 64'(DAT_O), 64'(mon_e.dat));
        check("word_bits", 64'(BITS_O), 64'(mon_e.bits));
        check("word_cyc_we", 64'({CYC_O, WE_O}), 64'(2'b11));
      end
    end
  end

  // Issue one symbol and hold it until accepted (bounded)
  task automatic send(input logic [15:0] re, input logic [15:0] im);
    bit ok;
    DAT_I = {im, re};
    STB_I = 1'b1;
    WE_I  = 1'b1;
    ok    = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK_I);
    #1;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got ACK_O=0 expected 1 for 0x%0h", {im, re});
    end
  endtask

  task automatic start_frame(input logic [1:0] m);
    MOD_I = m;
    CYC_I = 1'b1;
  endtask

  // End frame and wait for all expected words and CYC_O to drop (bounded)
  task automatic end_frame();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK_I);
      if (!CYC_O && !STB_O && sb.size() == 0) break;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("cyc_o_low", 64'(CYC_O), 64'd0);
    @(posedge CLK_I);
    #1;
    repeat (2) @(posedge CLK_I);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge CLK_I);
    #1;
    check("reset_outputs", 64'({DAT_O, BITS_O, STB_O, CYC_O, WE_O, ACK_O}), 64'd0);
    RST_I = 1'b1;
    ACK_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;

    // QPSK: 16 x (+,-) -> 0x55555555, STB_O one cycle after 16th accept
    start_frame(2'b01);
    sb.push_back('{32'h5555_5555, 6'd32});
    for (int i = 0; i < 16; i++) begin
      send(16'sd5734, -16'sd5734);
      if (i == 14) check("latency_pre", 64'(STB_O), 64'd0);
      if (i == 15) check("latency_word", 64'({STB_O, DAT_O}), 64'({1'b1, 32'h5555_5555}));
    end
    end_frame();

    // MOD_I=11: 64-QAM when built, otherwise sliced as 16-QAM
    start_frame(2'b11);
`ifdef QAM64_EN
    sb.push_back('{32'hC71C_71C7, 6'd32});
    sb.push_back('{32'h0000_0001, 6'd4});
`else
    sb.push_back('{32'h0033_3333, 6'd24});
`endif
    for (int i = 0; i < 6; i++) send(16'sd3792, -16'sd8848);
    end_frame();

    // 16-QAM threshold edges: 5181 -> 0xD, 5180 -> 0xF, -32768 -> 0xC
    start_frame(2'b10);
    sb.push_back('{32'h0000_0CFD, 6'd12});
    send(16'sd5181, 16'sd0);
    send(16'sd5180, 16'sd0);
    send(16'h8000, 16'sd0);
    end_frame();

    // Stall: word held with ACK_I=0 for 10 cycles, then released
    ACK_I = 1'b0;
    start_frame(2'b01);
    sb.push_back('{32'h5555_5555, 6'd32});
    sb.push_back('{32'hAAAA_AAAA, 6'd32});
    for (int i = 0; i < 16; i++) send(16'sd5734, -16'sd5734);
    DAT_I = {16'sd5734, -16'sd5734};
    STB_I = 1'b1;
    WE_I  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_I);
      check("stall_ack_low", 64'(ACK_O), 64'd0);
      check("stall_hold", 64'({STB_O, BITS_O, DAT_O}), 64'({1'b1, 6'd32, 32'h5555_5555}));
    end
    @(posedge CLK_I);
    #1;
    ACK_I = 1'b1;
    for (int i = 0; i < 16; i++) send(-16'sd5734, 16'sd5734);
    end_frame();

    // Reset mid-frame at fill=20, then BPSK frame must carry no stale bits
    start_frame(2'b01);
    sb.push_back('{32'h5555_5555, 6'd32});
    for (int i = 0; i < 26; i++) send(16'sd5734, -16'sd5734);
    check("pre_reset_sb", 64'(sb.size()), 64'd0);
    #2;
    RST_I = 1'b0;
    CYC_I = 1'b0;
    #1;
    check("midreset_outputs", 64'({DAT_O, BITS_O, STB_O, CYC_O, WE_O, ACK_O}), 64'd0);
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    start_frame(2'b00);
    sb.push_back('{32'h0000_001F, 6'd5});
    for (int i = 0; i < 5; i++) send(16'sd1000, 16'sd0);
    end_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
